// File: rtl/ram_burst_reader.sv
// Burst read initiator for a 1024x64 RAM with one-cycle read latency and a 4-entry output FIFO.
// Optional wrap bursts are enabled by defining RAM_BURST_READER_WRAP_EN.
module ram_burst_reader #(
  parameter int AW = 10,
  parameter int DW = 64,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_len,
`ifdef RAM_BURST_READER_WRAP_EN
  input  logic          req_wrap,
`endif
  output logic [AW-1:0] ram_raddr,
  input  logic [DW-1:0] ram_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic          rdy_en;
  logic [AW-1:0] base, cur_addr;
  logic [LW-1:0] len;
  logic          wrap_in, wrap_q;
  logic [LW:0]   issued;
  logic          vld_p0, last_p0;
  logic          vld_p1, last_p1;
  logic [DW:0]   fifo_mem [4];
  logic [1:0]    wr_ptr, rd_ptr;
  logic [2:0]    fifo_cnt, inflight;
  logic [DW:0]   head;
  logic          accept, issue, push, pop, done;

`ifdef RAM_BURST_READER_WRAP_EN
  assign wrap_in = req_wrap;
`else
  assign wrap_in = 1'b0;
`endif

  // Wrap only applies to power-of-two lengths; otherwise fall back to incrementing.
  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                             input logic [LW-1:0] l, input logic w);
    logic [AW-1:0] mask;
    logic [LW:0]   lp1;
    mask = AW'(l);
    lp1  = {1'b0, l} + 1'b1;
    if (w && ((lp1 & {1'b0, l}) == '0))
      return (b & ~mask) | ((a + 1'b1) & mask);
    return a + 1'b1;
  endfunction

  assign accept   = req_valid && req_ready;
  assign inflight = fifo_cnt + 3'(vld_p0) + 3'(vld_p1);
  assign issue    = (state == BUSY) && (issued <= {1'b0, len}) && (inflight < 3'd4);
  assign push     = vld_p1;
  assign head     = fifo_mem[rd_ptr];
  assign out_valid = (fifo_cnt != 3'd0);
  assign out_data  = out_valid ? head[DW-1:0] : '0;
  assign out_last  = out_valid && head[DW];
  assign pop      = out_valid && out_ready;
  assign done     = pop && head[DW];

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE:    req_ready = rdy_en;
      BUSY:    busy      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rdy_en    <= 1'b0;
      issued    <= '0;
      ram_raddr <= '0;
      vld_p0    <= 1'b0;
      vld_p1    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (accept) issued <= '0;
      else if (issue) issued <= issued + 1'b1;
      // stage A: address presented to the RAM
      if (issue) ram_raddr <= cur_addr;
      vld_p0 <= issue;
      // stage B: RAM data valid on ram_rd
      vld_p1 <= vld_p0;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      base     <= req_addr;
      cur_addr <= req_addr;
      len      <= req_len;
      wrap_q   <= wrap_in;
    end else if (issue) begin
      cur_addr <= next_addr(cur_addr, base, len, wrap_q);
    end
    if (issue) last_p0 <= (issued == {1'b0, len});
    last_p1 <= last_p0;
    if (push) fifo_mem[wr_ptr] <= {last_p1, ram_rd};
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Directed bench for ram_burst_reader with a behavioural one-cycle-latency RAM.
// Wrap-burst steps run only when RAM_BURST_READER_WRAP_EN is defined.
module tb_ram_burst_reader;
  localparam int AW = 10;
  localparam int DW = 64;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [LW-1:0] req_len = '0;
`ifdef RAM_BURST_READER_WRAP_EN
  logic          req_wrap = 1'b0;
`endif
  logic [AW-1:0] ram_raddr;
  logic [DW-1:0] ram_rd = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  logic [63:0] mem [1024];
  logic [63:0] expv [32];
  int checks = 0;
  int failures = 0;

  ram_burst_reader #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_len(req_len),
`ifdef RAM_BURST_READER_WRAP_EN
    .req_wrap(req_wrap),
`endif
    .ram_raddr(ram_raddr), .ram_rd(ram_rd), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ram_rd <= mem[ram_raddr];

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic request(input logic [AW-1:0] a, input logic [LW-1:0] l);
    int t = 0;
    req_addr  = a;
    req_len   = l;
    req_valid = 1'b1;
    while (!req_ready && t < 50) begin
      step();
      t++;
    end
    chk("req_ready_wait", 64'(req_ready), 64'd1);
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int n, input bit bp);
    int got = 0;
    int cyc = 0;
    int low = 0;
    while (got < n && cyc < 3000) begin
      if (!bp || got < 3) out_ready = 1'b1;
      else if (low < 10) begin
        out_ready = 1'b0;
        low++;
      end else out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        chk({tag, "_data"}, out_data, expv[got]);
        chk({tag, "_last"}, 64'(out_last), 64'(got == n - 1));
        got++;
      end
      step();
      cyc++;
    end
    out_ready = 1'b1;
    chk({tag, "_count"}, 64'(got), 64'(n));
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_ready_after"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 64'(i);
    mem[5]   = 64'hDEAD_BEEF_0123_4567;
    mem[100] = 64'hA5A5_0000_0000_0064;
    mem[101] = 64'h5A5A_0000_0000_0065;

    // Reset held 3 cycles with a pending request
    rst = 1'b0;
    req_valid = 1'b1;
    req_addr = 10'd7;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_raddr", 64'(ram_raddr), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd0);
    end
    rst = 1'b1;
    req_valid = 1'b0;
    chk("rel1_req_ready", 64'(req_ready), 64'd0);
    step();
    chk("rel2_req_ready", 64'(req_ready), 64'd1);
    chk("rel2_busy", 64'(busy), 64'd0);

    // Single beat, 3-cycle latency
    request(10'd5, 8'd0);
    chk("single_busy", 64'(busy), 64'd1);
    chk("single_req_ready", 64'(req_ready), 64'd0);
    step();
    chk("single_raddr", 64'(ram_raddr), 64'd5);
    chk("single_valid_c1", 64'(out_valid), 64'd0);
    step();
    chk("single_valid_c2", 64'(out_valid), 64'd0);
    step();
    chk("single_valid_c3", 64'(out_valid), 64'd1);
    chk("single_data", out_data, 64'hDEAD_BEEF_0123_4567);
    chk("single_last", 64'(out_last), 64'd1);
    step();
    chk("single_valid_after", 64'(out_valid), 64'd0);
    chk("single_busy_after", 64'(busy), 64'd0);
    chk("single_ready_after", 64'(req_ready), 64'd1);
    mem[5] = 64'd5;

    // Full rate across the 1023->0 boundary
    request(10'd1020, 8'd7);
    step();
    step();
    chk("full_valid_pre", 64'(out_valid), 64'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("full_valid", 64'(out_valid), 64'd1);
      chk("full_data", out_data, 64'((1020 + i) % 1024));
      chk("full_last", 64'(out_last), 64'(i == 7));
      step();
    end
    chk("full_valid_after", 64'(out_valid), 64'd0);
    chk("full_busy_after", 64'(busy), 64'd0);
    chk("full_ready_after", 64'(req_ready), 64'd1);

    // Backpressure: stall at beat 3, then random ready
    for (int i = 0; i < 32; i++) expv[i] = 64'(i);
    request(10'd0, 8'd31);
    drain("bp", 32, 1'b1);

`ifdef RAM_BURST_READER_WRAP_EN
    req_wrap = 1'b1;
    expv[0] = 64'h0D; expv[1] = 64'h0E; expv[2] = 64'h0F; expv[3] = 64'h08;
    expv[4] = 64'h09; expv[5] = 64'h0A; expv[6] = 64'h0B; expv[7] = 64'h0C;
    request(10'h0D, 8'd7);
    drain("wrap8", 8, 1'b0);
    for (int i = 0; i < 6; i++) expv[i] = 64'(13 + i);
    request(10'h0D, 8'd5);
    drain("wrap6_incr", 6, 1'b0);
    req_wrap = 1'b0;
`endif

    // Reset in the middle of a 16-beat burst
    request(10'd200, 8'd15);
    for (int i = 0; i < 6; i++) step();
    chk("mid_beat4_valid", 64'(out_valid), 64'd1);
    chk("mid_beat4_data", out_data, 64'd203);
    rst = 1'b0;
    step();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    rst = 1'b1;
    step();
    step();
    expv[0] = 64'hA5A5_0000_0000_0064;
    expv[1] = 64'h5A5A_0000_0000_0065;
    request(10'd100, 8'd1);
    drain("post_rst", 2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("post_rst_no_stale", 64'(out_valid), 64'd0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
